// File: rtl/ir_fetch_queue.sv
// Instruction register with an integrated prefetch queue between fetch and decode.
// When empty, the last issued word stays on out_data so a stalled decoder sees a stable word.
module ir_fetch_queue #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A full queue never accepts a word, even alongside a pop: no fall-through.
    assign w_push  = in_valid && !w_full && !flush;
    assign w_pop   = !w_empty && out_ready && !flush;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? r_last : r_mem[r_rp];
    assign count     = r_count;

    // Storage array; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Pointers, occupancy and last-issued word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp   <= r_rp + AW'(1);
                r_last <= r_mem[r_rp];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed, table-driven bench for ir_fetch_queue (WIDTH=16, DEPTH=4).
module tb_ir_fetch_queue;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    ir_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_od;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic rst_n, input logic fl, input logic iv,
                                input logic [15:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov,
                                input logic [15:0] e_od, input int e_cnt);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic fl, input logic iv,
                         input logic [15:0] id, input logic ordy);
        reset     = rst_n;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // reset held two cycles, then idle for five
        add(0,0,0,16'h0,0, 1,0,16'h0000,0);
        add(0,0,0,16'h0,0, 1,0,16'h0000,0);
        for (int i = 0; i < 5; i++) add(1,0,0,16'h0,0, 1,0,16'h0000,0);
        // fill to full, fifth word refused
        add(1,0,1,16'hA001,0, 1,1,16'hA001,1);
        add(1,0,1,16'hA002,0, 1,1,16'hA001,2);
        add(1,0,1,16'hA003,0, 1,1,16'hA001,3);
        add(1,0,1,16'hA004,0, 0,1,16'hA001,4);
        add(1,0,1,16'hA005,0, 0,1,16'hA001,4);
        // drain; last word held on empty
        add(1,0,0,16'h0,1, 1,1,16'hA002,3);
        add(1,0,0,16'h0,1, 1,1,16'hA003,2);
        add(1,0,0,16'h0,1, 1,1,16'hA004,1);
        add(1,0,0,16'h0,1, 1,0,16'hA004,0);
        add(1,0,0,16'h0,1, 1,0,16'hA004,0);
        // simultaneous push/pop at count 2
        add(1,0,1,16'hB001,0, 1,1,16'hB001,1);
        add(1,0,1,16'hB002,0, 1,1,16'hB001,2);
        add(1,0,1,16'hB003,1, 1,1,16'hB002,2);
        add(1,0,0,16'h0,1,    1,1,16'hB003,1);
        add(1,0,0,16'h0,1,    1,0,16'hB003,0);
        // simultaneous push/pop at full: pop only
        add(1,0,1,16'hC001,0, 1,1,16'hC001,1);
        add(1,0,1,16'hC002,0, 1,1,16'hC001,2);
        add(1,0,1,16'hC003,0, 1,1,16'hC001,3);
        add(1,0,1,16'hC004,0, 0,1,16'hC001,4);
        add(1,0,1,16'hC005,1, 1,1,16'hC002,3);
        add(1,0,0,16'h0,1,    1,1,16'hC003,2);
        add(1,0,0,16'h0,1,    1,1,16'hC004,1);
        add(1,0,0,16'h0,1,    1,0,16'hC004,0);
        // flush with last = BEEF and 3 queued
        add(1,0,1,16'hBEEF,0, 1,1,16'hBEEF,1);
        add(1,0,0,16'h0,1,    1,0,16'hBEEF,0);
        add(1,0,1,16'hD001,0, 1,1,16'hD001,1);
        add(1,0,1,16'hD002,0, 1,1,16'hD001,2);
        add(1,0,1,16'hD003,0, 1,1,16'hD001,3);
        add(1,1,1,16'h1234,1, 1,0,16'hBEEF,0);
        add(1,0,0,16'h0,0,    1,0,16'hBEEF,0);
        add(1,0,1,16'hE001,0, 1,1,16'hE001,1);
        add(1,0,0,16'h0,1,    1,0,16'hE001,0);
        // reset mid-operation with in_valid high
        add(1,0,1,16'hF001,0, 1,1,16'hF001,1);
        add(1,0,1,16'hF002,0, 1,1,16'hF001,2);
        add(0,0,1,16'hF003,0, 1,0,16'h0000,0);
        add(1,0,1,16'hF004,0, 1,1,16'hF004,1);
        add(1,0,1,16'hF005,1, 1,1,16'hF005,1);
        add(1,0,0,16'h0,1,    1,0,16'hF005,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].e_od));
            check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_cnt));
        end

        // streaming 12 words through the 4-entry ring: head is always the word just pushed
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, 1'b1, 16'(16'h0100 + k), 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d out_data", k), 32'(out_data), 32'(16'h0100 + k));
            check($sformatf("stream%0d count", k),    32'(count),    32'd1);
            check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        check("stream_end count",     32'(count),     32'd0);
        check("stream_end out_valid", 32'(out_valid), 32'd0);
        check("stream_end out_data",  32'(out_data),  32'h010B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ir_fetch_queue.md
# ir_fetch_queue

Parametrised instruction register with an integrated prefetch queue. It sits between the instruction-memory fetch path and the decoder, and buffers up to DEPTH fetched instruction words with valid/ready handshakes on both sides. It supports a single-cycle flush for branches and jumps. When empty, it keeps presenting the last instruction it issued, so the decoder sees a stable word while stalled.

## Interface
Parameters:
- WIDTH, 16, instruction word width in bits (≥ 8)
- DEPTH, 4, queue capacity in words; power of two, ≥ 2
- CW, $clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-low; clock clk
- flush  input  1  discard all queued words this cycle
- in_valid  input  1  fetch side presents a word
- in_data  input  WIDTH  fetched instruction word
- in_ready  output  1  queue can accept a word
- out_valid  output  1  head word is valid for the decoder
- out_data  output  WIDTH  head word if non-empty, else last issued word
- out_ready  input  1  decoder consumes the head word
- count  output  CW  number of words currently queued (0..DEPTH)

## Operation
- Storage: DEPTH×WIDTH register array, with write pointer wp and read pointer rp, each log2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Occupancy is held in the count register. Full is count == DEPTH; empty is count == 0.
- The last register (WIDTH bits) holds the most recently popped word.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- in_ready = !full. It is a function of registered count only and never depends on out_ready, so there is no combinational path from in_* to out_* or back.
- out_valid = !empty.
- out_data = mem[rp] when !empty, otherwise last. It is combinational from registers only.
- On push: mem[wp] ← in_data, wp ← wp+1.
- On pop: last ← mem[rp], rp ← rp+1.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together (possible only when 0 < count < DEPTH)
- Push is not possible when full, even if a pop happens in the same cycle. This fall-through is deliberately absent.
- Pop is not possible when empty. An input word never bypasses to the output in the same cycle.
- Flush has highest priority after reset:
  - wp, rp and count all go to 0.
  - Any concurrent push and pop are ignored.
  - last is unchanged.
  - Array contents are don't-care.
- Reset (reset == 0 at posedge):
  - wp, rp, count and last all go to 0.
  - Reset overrides flush, push and pop.
  - Array contents need not be cleared.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, count = 0.
- Latency: a word pushed at edge N is visible on out_data with out_valid = 1 after edge N (one cycle minimum).
- Throughput: one push and one pop per cycle, sustained while 0 < count < DEPTH.
- Full boundary:
  - After the DEPTH-th push, in_ready = 0 in the next cycle.
  - in_ready returns to 1 the cycle after a pop.
- Empty boundary: after the last pop, out_valid = 0 and out_data = the popped word (via last), held indefinitely.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no loss or reordering. Words exit in strict FIFO order.
- Flush mid-stream:
  - The cycle after flush: count = 0, out_valid = 0, in_ready = 1, out_data = last.
  - A word presented with in_valid during the flush cycle is dropped. The fetch side must re-present it.
- Reset mid-operation behaves as flush plus last cleared. Outputs take their reset values the cycle after the edge.

## Test plan
- Reset/idle:
  - Stimulus: hold reset = 0 for 2 cycles, then release with no traffic.
  - Required: in_ready = 1, out_valid = 0, out_data = 16'h0000, count = 0, stable for 5 cycles.
- Fill and drain (DEPTH = 4):
  - Stimulus: push 16'hA001..16'hA004 with out_ready = 0.
  - Required: count steps 1,2,3,4 and in_ready = 0 at count 4; a 5th in_valid word 16'hA005 is not accepted.
  - Then drain with out_ready = 1. Required: out_data sequence A001, A002, A003, A004; afterwards out_valid = 0 and out_data holds 16'hA004.
- Streaming wrap:
  - Stimulus: 12 words 16'h0100..16'h010B with in_valid = 1 and out_ready = 1 continuously.
  - Required: all 12 words out in order; count never exceeds 1 after the first cycle; no drops across pointer wrap.
- Simultaneous push/pop at count = 2:
  - Required: count stays 2, the head advances, and the tail word is stored.
- Simultaneous push/pop at full:
  - Required: the pop occurs, the push is rejected, and count = 3.
- Flush:
  - Stimulus: with 3 words queued and last = 16'hBEEF, assert flush together with in_valid (16'h1234) and out_ready.
  - Required next cycle: count = 0, out_valid = 0, out_data = 16'hBEEF. 16'h1234 never appears on out_data.
- Reset mid-operation:
  - Stimulus: with 2 words queued, assert reset for 1 cycle while in_valid = 1.
  - Required: count = 0, out_data = 0, in_ready = 1; the next push is output first, in normal order.
